// File: rtl/bin_to_bcd_pkg.sv
// bin_to_bcd_pkg: shared FSM states, blank nibble and power-of-ten helper for bin_to_bcd_seq
package bin_to_bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam logic [3:0] BLANK_NIBBLE = 4'hF;
  localparam int POW_W = 256;
  function automatic logic [POW_W-1:0] pow10(input int n);
    pow10 = POW_W'(1);
    for (int i = 0; i < n; i++) pow10 = pow10 * POW_W'(10);
  endfunction
endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to nibbles of 5 or more
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock
// Define BIN_TO_BCD_BLANK_EN to write leading zero digits as 4'hF.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int NUM_WIDTH  = 32,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic [NUM_WIDTH-1:0]    number_in_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_out_o,
  output logic                    overflow_o
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_WIDTH + 1);
  localparam logic [POW_W-1:0] LIMIT = pow10(NUM_DIGITS);
  state_e               state_q, state_d;
  logic [NUM_WIDTH-1:0] sr_q, sr_d, sr_sh;
  logic [BW-1:0]        acc_q, acc_d, acc_sh, adj, result, bcd_q, bcd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d, in_range;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (.d_i(acc_q[4*g+:4]), .d_o(adj[4*g+:4]));
  end
  // The accumulator MSB falls off the top here; it is zero for in-range inputs.
  assign {acc_sh, sr_sh} = {adj, sr_q} << 1;
  assign in_range = POW_W'(number_in_i) < LIMIT;
`ifdef BIN_TO_BCD_BLANK_EN
  function automatic logic [BW-1:0] blank(input logic [BW-1:0] v);
    logic lead;
    blank = v;
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lead = lead && (v[4*i+:4] == 4'd0);
      if (lead) blank[4*i+:4] = BLANK_NIBBLE;
    end
  endfunction
  assign result = blank(acc_sh);
`else
  assign result = acc_sh;
`endif
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    if (state_q == SHIFT) begin
      sr_d  = sr_sh;
      acc_d = acc_sh;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        bcd_d   = result;
        ovf_d   = 1'b0;
        state_d = DONE;
      end
    end else begin
      state_d = IDLE;
      if (start_i && in_range) begin
        sr_d    = number_in_i;
        acc_d   = '0;
        cnt_d   = CW'(NUM_WIDTH);
        state_d = SHIFT;
      end else if (start_i) begin
        bcd_d   = {NUM_DIGITS{BLANK_NIBBLE}};
        ovf_d   = 1'b1;
        state_d = DONE;
      end
    end
  end
  assign busy_o     = state_q == SHIFT;
  assign done_o     = state_q == DONE;
  assign bcd_out_o  = bcd_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for bin_to_bcd_seq with directed vectors
module tb_bin_to_bcd_seq;
  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          due;
    int          busy;
  } exp_t;
`ifdef BIN_TO_BCD_BLANK_EN
  localparam logic [15:0] E0 = 16'hFFF0, E57 = 16'hFF57, E42 = 16'hFF42, E8 = 16'hFFF8;
  localparam logic [15:0] E10 = 16'hFF10, E105 = 16'hF105;
`else
  localparam logic [15:0] E0 = 16'h0000, E57 = 16'h0057, E42 = 16'h0042, E8 = 16'h0008;
  localparam logic [15:0] E10 = 16'h0010, E105 = 16'h0105;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] number = '0;
  logic        busy_o, done_o, overflow_o;
  logic [15:0] bcd_out_o;
  int          passed = 0, total = 0, cyc = 0, busy_cnt = 0;
  logic        prev_done = 1'b0;
  exp_t        q[$];

  bin_to_bcd_seq dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .number_in_i(number),
    .busy_o(busy_o), .done_o(done_o), .bcd_out_o(bcd_out_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Called at a negedge; the following posedge accepts the request.
  task automatic issue(input logic [31:0] n, input logic [15:0] b, input logic o);
    exp_t e;
    start = 1'b1;
    number = n;
    @(posedge clk);
    #1;
    e.bcd = b;
    e.ovf = o;
    e.due = o ? cyc : cyc + 32;
    e.busy = o ? 0 : 32;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done_o) chk("done_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) busy_cnt = 0;
    else begin
      if (busy_o) busy_cnt++;
      if (done_o && prev_done) chk("done_consecutive", 1, 0);
      if (done_o) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("bcd_out", bcd_out_o, e.bcd);
          chk("overflow", overflow_o, e.ovf);
          chk("done_cycle", cyc, e.due);
          chk("busy_cycles", busy_cnt, e.busy);
        end
        busy_cnt = 0;
      end
    end
    prev_done = done_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_bcd", bcd_out_o, 0);
    chk("reset_ovf", overflow_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1234, 16'h1234, 1'b0);
    chk("busy_after_accept", busy_o, 1);
    wait_done();
    repeat (3) @(negedge clk);
    issue(10000, 16'hFFFF, 1'b1);
    wait_done();
    repeat (2) @(negedge clk);
    issue(9999, 16'h9999, 1'b0);
    wait_done();
    issue(0, E0, 1'b0);
    wait_done();
    repeat (2) @(negedge clk);
    issue(57, E57, 1'b0);
    wait_done();
    @(negedge clk);
    issue(10, E10, 1'b0);
    wait_done();
    @(negedge clk);
    issue(105, E105, 1'b0);
    wait_done();
    @(negedge clk);
    issue(32'hFFFF_FFFF, 16'hFFFF, 1'b1);
    wait_done();
    @(negedge clk);
    issue(42, E42, 1'b0);
    repeat (8) @(negedge clk);
    start = 1'b1;
    number = 77;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    chk("held_bcd", bcd_out_o, E42);
    chk("held_idle", busy_o | done_o, 0);
    start = 1'b1;
    number = 200;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("busy_before_reset", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy_o, 0);
    chk("async_rst_bcd", bcd_out_o, 0);
    chk("async_rst_ovf", overflow_o, 0);
    chk("async_rst_done", done_o, 0);
    repeat (40) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(8, E8, 1'b0);
    wait_done();
    repeat (40) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter NUM_WIDTH, default 32: width of the binary input value.
REQ-002 Parameter NUM_DIGITS, default 4: number of BCD digits produced; 10^NUM_DIGITS is the overflow threshold.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Start  input  1  conversion request; sampled on rising Clk.
REQ-006 Number_in  input  NUM_WIDTH  unsigned binary value; captured on the edge that accepts Start.
REQ-007 Busy  output  1  high while a conversion is shifting.
REQ-008 Done  output  1  single-cycle pulse; result valid.
REQ-009 Bcd_out  output  4*NUM_DIGITS  result digits; nibble 0 (LSBs) is the units digit; registered, held between completions.
REQ-010 Overflow  output  1  high when the last accepted value was >= 10^NUM_DIGITS; held with Bcd_out.

Function
REQ-011 Three-state FSM: IDLE, SHIFT, DONE; Busy = (state == SHIFT).
REQ-012 Start is accepted in IDLE or DONE only; it is ignored in SHIFT, with no effect on the conversion in flight.
REQ-013 On the accepting edge with Number_in < 10^NUM_DIGITS, the block loads the shift register with Number_in, clears the BCD accumulator, sets the bit counter to NUM_WIDTH, and enters SHIFT.
REQ-014 Each SHIFT edge performs one double-dabble step: first add 3 to every accumulator nibble >= 5, then shift {accumulator, shift register} left by one bit; the counter decrements by 1.
REQ-015 On the edge performing the NUM_WIDTH-th shift, the final accumulator is written to Bcd_out, Overflow is cleared, Done goes high and the state becomes DONE; latency = NUM_WIDTH edges after the accepting edge (32 for the default).
REQ-016 On the accepting edge with Number_in >= 10^NUM_DIGITS, the block skips SHIFT: Bcd_out = all nibbles 4'hF, Overflow = 1, state DONE; Done is high in the very next cycle.
REQ-017 DONE lasts exactly one cycle and returns to IDLE unless Start is high, in which case a new conversion is accepted (back-to-back operation); Done never stays high for 2 consecutive cycles.
REQ-018 Accumulator bits shifted beyond 4*NUM_DIGITS are discarded; these bits are always zero for in-range inputs.
REQ-019 The 10^NUM_DIGITS comparison uses at least NUM_WIDTH+1 bits, so no truncation occurs for any parameter choice.

Reset
REQ-020 Rst_n low forces IDLE immediately: Busy=0, Done=0, Bcd_out=0, Overflow=0, counter=0, shift register=0.
REQ-021 Reset during SHIFT abandons the conversion; no Done pulse is issued for it.
REQ-022 The first Start after Rst_n rises is accepted normally.

Configuration
REQ-023 The macro BIN_TO_BCD_BLANK_EN controls leading-zero blanking.
REQ-024 With BIN_TO_BCD_BLANK_EN defined, on completion every zero nibble more significant than the highest non-zero nibble is written as 4'hF; nibble 0 is never blanked; the overflow result is unchanged.
REQ-025 Without BIN_TO_BCD_BLANK_EN, Bcd_out carries plain BCD including leading zeros.

Structure
REQ-026 Shared package bin_to_bcd_pkg holds the FSM state typedef, BLANK_NIBBLE = 4'hF, and a helper function computing 10^NUM_DIGITS.
REQ-027 Sub-module bcd_add3 is combinational: 4-bit in, 4-bit out, adds 3 when the input is >= 5; the block instantiates it once per digit.
REQ-028 Bcd_out nibble ordering matches the downstream display digit multiplexer (digit 0 = rightmost).

Verification
REQ-029 Number_in=1234, Start 1 cycle, blanking off -> Busy for 32 cycles, Done pulse 32 edges after acceptance, Bcd_out=16'h1234, Overflow=0.
REQ-030 Number_in=10000 -> Done the next cycle, Bcd_out=16'hFFFF, Overflow=1, Busy never high.
REQ-031 Number_in=9999 then 0, back-to-back (Start high during DONE) -> 16'h9999 then 16'h0000 (16'hFFF0 with BIN_TO_BCD_BLANK_EN); Done high on 2 non-consecutive cycles.
REQ-032 Number_in=57 with BIN_TO_BCD_BLANK_EN -> Bcd_out=16'hFF57; without the macro -> 16'h0057.
REQ-033 Start=1 with Number_in=42, then Start=1 with 77 at cycle 10 -> the second Start is ignored; a single Done; Bcd_out=16'h0042.
REQ-034 Rst_n low at cycle 15 of a conversion -> all outputs 0 immediately; no Done; a new Start of 8 after release -> 16'h0008.
